// File: rtl/toy_lsu_ld_resp_buf.sv
// toy_lsu_ld_resp_buf: offset-aligning in-order load response FIFO feeding writeback
module toy_lsu_ld_resp_buf #(
  parameter int DATA_WIDTH = 128,
  parameter int SB_WIDTH = 21,
  parameter int DEPTH = 4,
  parameter int REG_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cancel_en,
  input  logic                        mem_ack_vld,
  output logic                        mem_ack_rdy,
  input  logic [DATA_WIDTH-1:0]       mem_ack_data,
  input  logic [SB_WIDTH-1:0]         mem_ack_sideband,
  output logic                        wb_vld,
  input  logic                        wb_rdy,
  output logic [REG_WIDTH-1:0]        wb_data,
  output logic [SB_WIDTH-1:0]         wb_sideband,
  output logic [$clog2(DEPTH):0]      occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [SB_WIDTH-1:0] SB_MASK = {4'h0, {(SB_WIDTH-4){1'b1}}};
  logic [REG_WIDTH-1:0] data_q [DEPTH];
  logic [SB_WIDTH-1:0] sb_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] shifted;
  logic enq, deq;
  assign mem_ack_rdy = occupancy != OW'(DEPTH);
  assign wb_vld = (occupancy != '0) && !cancel_en;
  assign enq = mem_ack_vld && mem_ack_rdy && !cancel_en;
  assign deq = wb_vld && wb_rdy;
  assign shifted = mem_ack_data >> {mem_ack_sideband[SB_WIDTH-1 -: 4], 3'b000};
  assign wb_data = data_q[rd_ptr];
  assign wb_sideband = sb_q[rd_ptr];
  always_ff @(posedge clk) begin
    if (enq) begin
      data_q[wr_ptr] <= shifted[REG_WIDTH-1:0];
      sb_q[wr_ptr] <= mem_ack_sideband & SB_MASK;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || cancel_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(enq);
      rd_ptr <= rd_ptr + AW'(deq);
      occupancy <= occupancy + OW'(enq) - OW'(deq);
    end
  end
endmodule

// File: tb/tb_toy_lsu_ld_resp_buf.sv
// tb_toy_lsu_ld_resp_buf: scoreboard bench for the load response buffer
module tb_toy_lsu_ld_resp_buf;
  typedef struct packed {
    logic [31:0] d;
    logic [20:0] s;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cancel_en = 1'b0;
  logic mem_ack_vld = 1'b0;
  logic mem_ack_rdy;
  logic [127:0] mem_ack_data = '0;
  logic [20:0] mem_ack_sideband = '0;
  logic wb_vld;
  logic wb_rdy = 1'b0;
  logic [31:0] wb_data;
  logic [20:0] wb_sideband;
  logic [2:0] occupancy;
  int checks = 0;
  int failures = 0;
  int m_occ = 0;
  ent_t sbq[$];
  toy_lsu_ld_resp_buf dut (
    .clk(clk),
    .rst(rst),
    .cancel_en(cancel_en),
    .mem_ack_vld(mem_ack_vld),
    .mem_ack_rdy(mem_ack_rdy),
    .mem_ack_data(mem_ack_data),
    .mem_ack_sideband(mem_ack_sideband),
    .wb_vld(wb_vld),
    .wb_rdy(wb_rdy),
    .wb_data(wb_data),
    .wb_sideband(wb_sideband),
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] align(logic [127:0] d, logic [3:0] off);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++)
      if (int'(off) + b < 16) r[b*8 +: 8] = d[(int'(off) + b)*8 +: 8];
    return r;
  endfunction
  task automatic ack(logic v, logic [127:0] d, logic [3:0] off, logic [5:0] id);
    mem_ack_vld = v;
    mem_ack_data = d;
    mem_ack_sideband = {off, id, 6'(id + 6'd3), 1'b1, 1'b0, 3'b010};
  endtask
  task automatic cyc();
    bit enq = 0;
    bit deq = 0;
    ent_t e;
    @(negedge clk);
    chk("occupancy", 64'(occupancy), 64'(m_occ));
    chk("mem_ack_rdy", 64'(mem_ack_rdy), 64'(m_occ != 4));
    chk("wb_vld", 64'(wb_vld), 64'(m_occ != 0 && !cancel_en));
    if (m_occ != 0 && !cancel_en && wb_rdy) begin
      e = sbq.pop_front();
      chk("wb_data", 64'(wb_data), 64'(e.d));
      chk("wb_sideband", 64'(wb_sideband), 64'(e.s));
      deq = 1;
    end
    if (mem_ack_vld && m_occ != 4 && !cancel_en) begin
      sbq.push_back({align(mem_ack_data, mem_ack_sideband[20:17]), {4'h0, mem_ack_sideband[16:0]}});
      enq = 1;
    end
    if (cancel_en) begin
      sbq.delete();
      m_occ = 0;
    end else m_occ = m_occ + int'(enq) - int'(deq);
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_wb_vld", 64'(wb_vld), 64'd0);
    chk("rst_ack_rdy", 64'(mem_ack_rdy), 64'd1);
    ack(1, {64'h1122334455667788, 32'hDDCCBBAA, 32'h0}, 4'h4, 6'd5);
    mem_ack_sideband[10:5] = 6'd9;
    cyc();
    ack(0, '0, 4'h0, 6'd0);
    chk("single_vld", 64'(wb_vld), 64'd1);
    chk("single_data", 64'(wb_data), 64'hDDCCBBAA);
    chk("single_off", 64'(wb_sideband[20:17]), 64'd0);
    chk("single_id", 64'(wb_sideband[16:11]), 64'd5);
    chk("single_reg", 64'(wb_sideband[10:5]), 64'd9);
    wb_rdy = 1'b1;
    cyc();
    chk("single_drain_occ", 64'(occupancy), 64'd0);
    wb_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ack(1, rnd128(), 4'($urandom_range(0, 12)), 6'(i));
      cyc();
    end
    ack(0, '0, 4'h0, 6'd0);
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_rdy", 64'(mem_ack_rdy), 64'd0);
    wb_rdy = 1'b1;
    chk("head_id0", 64'(wb_sideband[16:11]), 64'd0);
    cyc();
    chk("rdy_after_deq", 64'(mem_ack_rdy), 64'd1);
    repeat (4) cyc();
    chk("drained", 64'(occupancy), 64'd0);
    wb_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ack(1, rnd128(), 4'($urandom_range(0, 15)), 6'(10 + i));
      cyc();
    end
    wb_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ack(1, rnd128(), 4'($urandom_range(0, 15)), 6'(20 + i));
      cyc();
    end
    ack(0, '0, 4'h0, 6'd0);
    chk("pushpop_occ", 64'(occupancy), 64'd2);
    repeat (3) cyc();
    wb_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ack(1, rnd128(), 4'($urandom_range(0, 15)), 6'(40 + i));
      cyc();
    end
    ack(1, rnd128(), 4'h1, 6'd63);
    cancel_en = 1'b1;
    wb_rdy = 1'b1;
    cyc();
    cancel_en = 1'b0;
    ack(0, '0, 4'h0, 6'd0);
    chk("cancel_occ", 64'(occupancy), 64'd0);
    chk("cancel_vld", 64'(wb_vld), 64'd0);
    repeat (3) cyc();
    ack(1, {8'h7F, 8'h80, 112'h0123456789ABCDEF0123456789AB}, 4'hE, 6'd7);
    wb_rdy = 1'b0;
    cyc();
    ack(0, '0, 4'h0, 6'd0);
    chk("hi_off_data", 64'(wb_data), 64'h00007F80);
    wb_rdy = 1'b1;
    cyc();
    wb_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ack(1, rnd128(), 4'($urandom_range(0, 15)), 6'(50 + i));
      cyc();
    end
    ack(0, '0, 4'h0, 6'd0);
    chk("pre_rst_occ", 64'(occupancy), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_vld", 64'(wb_vld), 64'd0);
    chk("async_rst_occ", 64'(occupancy), 64'd0);
    sbq.delete();
    m_occ = 0;
    #3;
    rst = 1'b0;
    wb_rdy = 1'b1;
    repeat (3) cyc();
    chk("post_rst_vld", 64'(wb_vld), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
